ras_ctrl: RTL

Request generator for the return address stack: `ras_ctrl` turns predecoded call/return events and pipeline advance/kill events into the stack's `push`/`pop`/`din`/`commit`/`flush` controls. It consumes the stack's `dout`/`valid` to produce registered return-target predictions. It sits between fetch predecode and the stack. It owns per-stage occupancy accounting so the stack's speculative stages never overflow or commit from empty.

---
 rtl/ras_pkg.sv | 24 ++
 rtl/ras_stage_cnt.sv | 35 +++
 rtl/ras_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/ras_pkg.sv
// Shared definitions for the return address stack and its request controller.
package ras_pkg;

  // Classification of a predecoded instruction as seen by the RAS.
  typedef enum logic [1:0] {
    RAS_OP_NONE = 2'b00,
    RAS_OP_CALL = 2'b01,
    RAS_OP_RET  = 2'b10
  } ras_op_t;

  // Counter width able to hold 0..max_branches inclusive.
  function automatic int RAS_CNT_W(input int max_branches);
    return $clog2(max_branches + 1);
  endfunction

  // A call that is also a return is classed as a call; the pop side is
  // handled separately so the pair becomes a top replace.
  function automatic ras_op_t ras_decode(input logic is_call, input logic is_ret);
    if (is_call) return RAS_OP_CALL;
    if (is_ret) return RAS_OP_RET;
    return RAS_OP_NONE;
  endfunction

endpackage

// File: rtl/ras_stage_cnt.sv
// Occupancy counter for one speculative RAS stage.
module ras_stage_cnt
  import ras_pkg::*;
#(
  parameter int MAX_BRANCHES = 16,
  parameter int CNT_W        = RAS_CNT_W(MAX_BRANCHES)
) (
  input  logic clk,
  input  logic rst_ni,
  input  logic inc,
  input  logic dec,
  input  logic clr,
  output logic full,
  output logic empty
);

  logic [CNT_W-1:0] cnt;

  // Clear wins over everything; inc and dec together cancel out.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !dec) begin
      cnt <= cnt + CNT_W'(1);
    end else if (dec && !inc) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign full  = (cnt >= CNT_W'(MAX_BRANCHES));
  assign empty = (cnt == '0);

endmodule

// File: rtl/ras_ctrl.sv
// Return address stack request generator: turns predecoded call/return and
// pipeline advance/kill events into stack push/pop/commit/flush controls,
// and registers return-target predictions from the stack top.
module ras_ctrl
  import ras_pkg::*;
#(
  parameter int STAGES       = 2,
  parameter int WIDTH        = 32,
  parameter int MAX_BRANCHES = 16
) (
  input  logic              clk,
  input  logic              rst_ni,
  input  logic              fetch_valid,
  output logic              fetch_ready,
  input  logic              fetch_is_call,
  input  logic              fetch_is_ret,
  input  logic              fetch_rvc,
  input  logic [WIDTH-1:0]  fetch_pc,
  input  logic [STAGES-1:0] adv_op,
  input  logic [STAGES-1:0] kill,
  output logic              push,
  output logic              pop,
  output logic [WIDTH-1:0]  din,
  output logic [STAGES-1:0] commit,
  output logic [STAGES-1:0] flush,
  input  logic [WIDTH-1:0]  ras_dout,
  input  logic              ras_valid,
  output logic              pred_valid,
  output logic [WIDTH-1:0]  pred_target,
  output logic              err
);

  localparam int CNT_W = RAS_CNT_W(MAX_BRANCHES);

  ras_op_t           op;
  logic              acc;
  logic              kill_any;
  logic              kill_q;
  logic              kill_run;
  logic              err_now;
  logic [STAGES-1:0] full;
  logic [STAGES-1:0] empty;
  logic [STAGES-1:0] full_up;
  logic [STAGES-1:0] cnt_inc;
  logic [STAGES-1:0] commit_raw;
  logic [STAGES:0]   commit_ext;

  assign op       = ras_decode(fetch_is_call, fetch_is_ret);
  assign kill_any = |kill;

  // A kill at stage k discards every younger stage as well.
  always_comb begin
    flush    = '0;
    kill_run = 1'b0;
    for (int j = STAGES - 1; j >= 0; j--) begin
      kill_run = kill_run | kill[j];
      flush[j] = kill_run;
    end
  end

  // full_up[i] is the fullness of the stage that stage i commits into;
  // the oldest stage commits out of the block and never sees a full target.
  assign full_up = {1'b0, full[STAGES-1:1]};

  // Resolve commits from the oldest stage down so a same-cycle commit
  // above frees room for the commit below it.
  always_comb begin
    commit_ext = '0;
    commit_raw = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      commit_raw[i] = adv_op[i] && !empty[i] && !flush[i];
      commit_ext[i] = commit_raw[i] && (!full_up[i] || commit_ext[i+1]);
    end
  end

  assign commit = commit_ext[STAGES-1:0];

  // Advance from an empty stage, or a commit held back for lack of room.
  assign err_now = (|(adv_op & empty)) || (|(commit_raw & ~commit));

  // Gated by rst_ni so nothing is offered while the block is held in reset.
  assign fetch_ready = rst_ni && (!full[0] || commit[0]) && !kill_any && !kill_q;

  assign acc  = fetch_valid && fetch_ready && (op != RAS_OP_NONE);
  assign push = acc && fetch_is_call;
  assign pop  = acc && fetch_is_ret;
  assign din  = fetch_pc + (fetch_rvc ? WIDTH'(2) : WIDTH'(4));

  // Stage 0 fills from accepted ops; each later stage fills from the commit below.
  assign cnt_inc = {commit[STAGES-2:0], acc};

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    ras_stage_cnt #(
      .MAX_BRANCHES (MAX_BRANCHES),
      .CNT_W        (CNT_W)
    ) u_cnt (
      .clk    (clk),
      .rst_ni (rst_ni),
      .inc    (cnt_inc[g]),
      .dec    (commit[g]),
      .clr    (flush[g]),
      .full   (full[g]),
      .empty  (empty[g])
    );
  end

  // Hold fetch off for one cycle after a kill so the restored top settles.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) kill_q <= 1'b0;
    else         kill_q <= kill_any;
  end

  // Sticky protocol error, cleared only by reset.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni)      err <= 1'b0;
    else if (err_now) err <= 1'b1;
  end

  // Capture the stack top seen while a return is accepted.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      pred_valid  <= 1'b0;
      pred_target <= '0;
    end else begin
      pred_valid <= pop && ras_valid;
      if (pop) pred_target <= ras_dout;
    end
  end

endmodule
